// File: rtl/tx_fifo_wr_arb.sv
// Write-side packet arbiter for the tx async FIFO: round-robin grant per packet,
// words tagged {src_id, last, data}, new packets held off while the FIFO is almost full.
module tx_fifo_wr_arb #(
  parameter int NUM_SRC    = 4,
  parameter int SRC_W      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 64
) (
  input  logic                            i_wclk,
  input  logic                            i_wrst_n,
  input  logic [NUM_SRC-1:0]              i_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_SRC-1:0]              i_last,
  output logic [NUM_SRC-1:0]              o_ready,
  output logic                            o_push,
  output logic [DATA_WIDTH+SRC_W:0]       o_wdata,
  input  logic                            i_wren,
  input  logic                            i_afull,
  output logic [NUM_SRC-1:0]              o_grant,
  output logic                            o_busy,
  output logic                            o_trunc
);

  localparam int CNT_W = $clog2(MAX_PKT);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]            state_reg;
  logic [NUM_SRC-1:0]    grant_reg;
  logic [SRC_W-1:0]      gidx_reg;
  logic [SRC_W-1:0]      rr_ptr_reg;
  logic [CNT_W-1:0]      beat_cnt_reg;
  logic                  trunc_reg;

  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic                  xfer;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  trunc_beat;
  logic                  accept;
  logic [SRC_W-1:0]      rr_ptr_next;

  // Two descending scans: the lowest index at/after rr_ptr wins, else the lowest below it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_valid[k] && (k < int'(rr_ptr_reg))) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(k);
      end
    end
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_valid[k] && (k >= int'(rr_ptr_reg))) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(k);
      end
    end
  end

  assign xfer        = (state_reg == ST_XFER);
  assign cur_valid   = i_valid[gidx_reg];
  assign cur_last    = i_last[gidx_reg];
  assign cur_data    = i_data[gidx_reg*DATA_WIDTH +: DATA_WIDTH];
  assign trunc_beat  = (beat_cnt_reg == CNT_W'(MAX_PKT - 1));
  assign accept      = xfer & i_wren;
  assign rr_ptr_next = (gidx_reg == SRC_W'(NUM_SRC - 1)) ? '0 : gidx_reg + 1'b1;

  assign o_push  = xfer & cur_valid;
  assign o_wdata = xfer ? {gidx_reg, cur_last | trunc_beat, cur_data} : '0;
  // Ready follows the controller's write enable only, so it never loops back into valid.
  assign o_ready = grant_reg & {NUM_SRC{i_wren}};
  assign o_grant = grant_reg;
  assign o_busy  = xfer;
  assign o_trunc = trunc_reg;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      gidx_reg     <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      trunc_reg    <= 1'b0;
    end else begin
      trunc_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_found && !i_afull) begin
            state_reg    <= ST_XFER;
            grant_reg    <= NUM_SRC'(1) << win_idx;
            gidx_reg     <= win_idx;
            beat_cnt_reg <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (cur_last || trunc_beat) begin
              state_reg    <= ST_IDLE;
              grant_reg    <= '0;
              rr_ptr_reg   <= rr_ptr_next;
              beat_cnt_reg <= '0;
              trunc_reg    <= trunc_beat & ~cur_last;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// Scoreboard bench for tx_fifo_wr_arb: a packet-level round-robin model predicts every
// written word; a negedge monitor pops and compares each beat the FIFO accepts.
module tb_tx_fifo_wr_arb;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DW = 8;
  localparam int MP = 4;
  localparam int WW = DW + SW + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    logic [WW-1:0] w;
    bit            tr;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NS-1:0]  valid = '0;
  logic [NS-1:0]  last = '0;
  logic [NS*DW-1:0] data = '0;
  logic [NS-1:0]  ready;
  logic [NS-1:0]  grant;
  logic           push;
  logic           wren;
  logic           afull = 1'b0;
  logic           busy;
  logic           trunc;
  logic [WW-1:0]  wdata;
  logic           full_r = 1'b0;

  assign wren = push & ~full_r;

  always #5 clk = ~clk;

  tx_fifo_wr_arb #(
    .NUM_SRC(NS), .SRC_W(SW), .DATA_WIDTH(DW), .MAX_PKT(MP)
  ) dut (
    .i_wclk(clk), .i_wrst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
    .o_ready(ready), .o_push(push), .o_wdata(wdata), .i_wren(wren), .i_afull(afull),
    .o_grant(grant), .o_busy(busy), .o_trunc(trunc)
  );

  word_t src_q[NS][$];
  word_t mdl_q[NS][$];
  exp_t  exp_q[$];

  int model_rr = 0;
  int n_checks = 0;
  int n_errors = 0;
  int p_full = 0, p_afull = 0, p_drop = 0;
  bit full_force = 0, afull_force = 0, gap_mode = 0;
  bit trunc_next = 0;
  int gap_stage = 0;
  int beats_seen = 0;
  int trunc_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_word(int k, logic [DW-1:0] d, logic l);
    word_t w;
    w.d = d;
    w.l = l;
    src_q[k].push_back(w);
    mdl_q[k].push_back(w);
  endtask

  task automatic load_pkt(int k, int n);
    for (int i = 0; i < n; i++) push_word(k, DW'($urandom), (i == n - 1));
  endtask

  // Packet-level reference: pick the first pending source from rr, emit its words up to
  // last or MAX_PKT beats (forcing last on a cut), then advance rr past the winner.
  task automatic run_model();
    int    w, n;
    bit    done;
    word_t wd;
    exp_t  e;
    forever begin
      w = -1;
      for (int i = 0; i < NS; i++) begin
        int k;
        k = (model_rr + i) % NS;
        if (w < 0 && mdl_q[k].size() > 0) w = k;
      end
      if (w < 0) break;
      n = 0;
      done = 0;
      while (!done) begin
        wd = mdl_q[w].pop_front();
        n++;
        e.tr = (n == MP) && !wd.l;
        e.w  = {SW'(w), wd.l || (n == MP), wd.d};
        exp_q.push_back(e);
        done = wd.l || (n == MP);
      end
      model_rr = (w + 1) % NS;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"},  32'(busy),  0);
    check({tag, "_push"},  32'(push),  0);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_trunc"}, 32'(trunc), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NS; k++) begin
      src_q[k].delete();
      mdl_q[k].delete();
    end
    exp_q.delete();
    trunc_next = 0;
    gap_stage  = 0;
    model_rr   = 0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d beats still expected after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beat(int budget);
    int b0 = beats_seen;
    int c = 0;
    while (beats_seen == b0 && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("beat_arrived", 32'(beats_seen != b0), 1);
  endtask

  // Source/FIFO driver: consumes words on ready, presents the next word, randomises stalls.
  initial begin
    logic [NS-1:0] acc;
    forever begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++)
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      full_r = full_force || ($urandom_range(99) < p_full);
      afull  = afull_force || ($urandom_range(99) < p_afull);
      for (int k = 0; k < NS; k++) begin
        if (src_q[k].size() > 0) begin
          valid[k] = !(grant[k] && ($urandom_range(99) < p_drop));
          data[k*DW +: DW] = src_q[k][0].d;
          last[k] = src_q[k][0].l;
        end else begin
          valid[k] = 1'b0;
          data[k*DW +: DW] = DW'($urandom);
          last[k] = 1'($urandom);
        end
      end
    end
  end

  // Monitor: every accepted beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("trunc_pulse", 32'(trunc), 32'(trunc_next));
      trunc_next = 0;
      if (trunc) trunc_cnt++;
      if (gap_stage == 1) begin
        check("gap_idle_busy", 32'(busy), 0);
        gap_stage = 2;
      end else if (gap_stage == 2) begin
        check("gap_next_grant", 32'(grant != 0), 1);
        gap_stage = 0;
      end
      if (push && wren) begin
        exp_t e;
        $display("beat src=%0d last=%0b data=0x%02h", wdata[WW-1 -: SW], wdata[DW], wdata[DW-1:0]);
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat_unexpected: got 0x%0h with nothing expected", wdata);
        end else begin
          e = exp_q.pop_front();
          check("wdata", 32'(wdata), 32'(e.w));
          trunc_next = e.tr;
          if (gap_mode && e.w[DW] && exp_q.size() > 0) gap_stage = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    check_reset_outputs("rst_init");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single source 1, three beats.
    push_word(1, 8'hA1, 1'b0);
    push_word(1, 8'hA2, 1'b0);
    push_word(1, 8'hA3, 1'b1);
    run_model();
    wait_drain(50);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_grant_after", 32'(grant), 0);

    // All four sources, back-to-back 2-beat packets from rr=0.
    do_reset();
    gap_mode = 1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NS; k++) load_pkt(k, 2);
    run_model();
    wait_drain(200);
    gap_mode = 0;

    // Almost-full held in IDLE blocks the grant until released.
    afull_force = 1;
    @(negedge clk);
    load_pkt(2, 2);
    run_model();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      check("afull_no_grant", 32'(grant), 0);
    end
    afull_force = 0;
    @(negedge clk);
    #2;
    check("afull_release_wait", 32'(grant), 0);
    @(negedge clk);
    #2;
    check("afull_grant2", 32'(grant), 32'h4);
    wait_drain(50);

    // Full FIFO stalls a packet mid-way for five cycles.
    load_pkt(0, 5);
    run_model();
    wait_beat(50);
    full_force = 1;
    @(negedge clk);
    #2;
    for (int c = 0; c < 5; c++) begin
      check("stall_push", 32'(push), 1);
      check("stall_ready", 32'(ready), 0);
      check("stall_busy", 32'(busy), 1);
      if (exp_q.size() > 0) check("stall_wdata", 32'(wdata), 32'(exp_q[0].w));
      @(negedge clk);
      #2;
    end
    full_force = 0;
    wait_drain(50);

    // Six-beat packet cut at MAX_PKT=4.
    trunc_cnt = 0;
    load_pkt(0, 6);
    run_model();
    wait_drain(80);
    check("trunc_count", 32'(trunc_cnt), 1);

    // Reset during beat 2 of a packet; rr must restart at 0.
    load_pkt(1, 1);
    run_model();
    wait_drain(50);
    load_pkt(3, 4);
    run_model();
    wait_beat(50);
    do_reset();
    load_pkt(3, 1);
    load_pkt(0, 1);
    run_model();
    wait_drain(50);

    // Randomised traffic with stalls, almost-full and valid gaps.
    p_full = 25;
    p_afull = 30;
    p_drop = 20;
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < NS; k++) load_pkt(k, int'($urandom_range(1, 6)));
    run_model();
    wait_drain(20000);
    p_full = 0;
    p_afull = 0;
    p_drop = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
